// File: rtl/sobel_pkg.sv
// Shared Sobel constants and the window feeder state encoding.
// The kernel controller uses the same frame geometry defaults.
package sobel_pkg;

   localparam int SOBEL_PIXEL_WIDTH  = 8;
   localparam int SOBEL_IMAGE_WIDTH  = 32;
   localparam int SOBEL_IMAGE_HEIGHT = 32;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_FETCH     = 3'd1,
      ST_LATCH     = 3'd2,
      ST_STROBE_HI = 3'd3,
      ST_STROBE_LO = 3'd4,
      ST_WAIT_ACK  = 3'd5,
      ST_NEXT_WIN  = 3'd6,
      ST_DONE      = 3'd7
   } feeder_state_e;

endpackage

// File: rtl/sobel_window_feeder_if.sv
// Frame-buffer read port plus the pixel-strobe link to the Sobel controller.
// master = feeder side, slave = memory/controller side.
interface sobel_window_feeder_if
   import sobel_pkg::*;
#(
   parameter int PIXEL_WIDTH = SOBEL_PIXEL_WIDTH,
   parameter int ADDR_WIDTH  = 10
);
   logic                   mem_rd_o;
   logic [ADDR_WIDTH-1:0]  mem_addr_o;
   logic [PIXEL_WIDTH-1:0] mem_data_i;
   logic [PIXEL_WIDTH-1:0] px_gray_o;
   logic                   px_enable_o;
   logic                   px_completed_i;

   modport master (
      output mem_rd_o, mem_addr_o, px_gray_o, px_enable_o,
      input  mem_data_i, px_completed_i
   );

   modport slave (
      input  mem_rd_o, mem_addr_o, px_gray_o, px_enable_o,
      output mem_data_i, px_completed_i
   );
endinterface

// File: rtl/sobel_window_addr_gen.sv
// Window/pixel position tracking for the feeder. The read address is kept
// incrementally (no multiplier): base_r is the top-left pixel of the current
// window, addr_r the pixel currently being fetched.
module sobel_window_addr_gen
   import sobel_pkg::*;
#(
   parameter int IMAGE_WIDTH  = SOBEL_IMAGE_WIDTH,
   parameter int IMAGE_HEIGHT = SOBEL_IMAGE_HEIGHT,
   parameter int ADDR_WIDTH   = 10
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  frame_clr_i,
   input  logic                  pix_step_i,
   input  logic                  win_step_i,
   output logic [ADDR_WIDTH-1:0] addr_o,
   output logic                  last_pix_o,
   output logic                  last_win_o
);
   localparam int ROW_W = $clog2(IMAGE_HEIGHT);
   localparam int COL_W = $clog2(IMAGE_WIDTH);
   localparam logic [ROW_W-1:0]      LAST_ROW  = ROW_W'(IMAGE_HEIGHT - 3);
   localparam logic [COL_W-1:0]      LAST_COL  = COL_W'(IMAGE_WIDTH - 3);
   // From the right pixel of a window row to the left pixel of the next row.
   localparam logic [ADDR_WIDTH-1:0] ROW_SKIP  = ADDR_WIDTH'(IMAGE_WIDTH - 2);
   // From the last window of a row to the first window of the next row.
   localparam logic [ADDR_WIDTH-1:0] WRAP_STEP = ADDR_WIDTH'(3);

   logic [ROW_W-1:0]      row_r;
   logic [COL_W-1:0]      col_r;
   logic [1:0]            krow_r;
   logic [1:0]            kcol_r;
   logic [ADDR_WIDTH-1:0] base_r;
   logic [ADDR_WIDTH-1:0] addr_r;

   // Step window position (r,c) and in-window pixel (k) as the FSM commands.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         row_r  <= '0;
         col_r  <= '0;
         krow_r <= 2'd0;
         kcol_r <= 2'd0;
         base_r <= '0;
         addr_r <= '0;
      end else if (frame_clr_i) begin
         row_r  <= '0;
         col_r  <= '0;
         krow_r <= 2'd0;
         kcol_r <= 2'd0;
         base_r <= '0;
         addr_r <= '0;
      end else if (win_step_i) begin
         krow_r <= 2'd0;
         kcol_r <= 2'd0;
         if (col_r != LAST_COL) begin
            col_r  <= col_r + COL_W'(1);
            base_r <= base_r + ADDR_WIDTH'(1);
            addr_r <= base_r + ADDR_WIDTH'(1);
         end else begin
            col_r  <= '0;
            row_r  <= row_r + ROW_W'(1);
            base_r <= base_r + WRAP_STEP;
            addr_r <= base_r + WRAP_STEP;
         end
      end else if (pix_step_i) begin
         if (kcol_r != 2'd2) begin
            kcol_r <= kcol_r + 2'd1;
            addr_r <= addr_r + ADDR_WIDTH'(1);
         end else begin
            kcol_r <= 2'd0;
            krow_r <= krow_r + 2'd1;
            addr_r <= addr_r + ROW_SKIP;
         end
      end
   end

   assign addr_o     = addr_r;
   assign last_pix_o = (krow_r == 2'd2) && (kcol_r == 2'd2);
   assign last_win_o = (row_r == LAST_ROW) && (col_r == LAST_COL);

endmodule

// File: rtl/sobel_window_feeder.sv
// Sobel window feeder: streams every 3x3 window of the frame buffer to the
// kernel controller one pixel per px_enable_o strobe, waiting for the
// controller's completion edge between windows.
// Optional watchdog on the acknowledge wait: define SOBEL_FEEDER_TIMEOUT_EN.
module sobel_window_feeder
   import sobel_pkg::*;
#(
   parameter int PIXEL_WIDTH  = SOBEL_PIXEL_WIDTH,
   parameter int IMAGE_WIDTH  = SOBEL_IMAGE_WIDTH,
   parameter int IMAGE_HEIGHT = SOBEL_IMAGE_HEIGHT,
   parameter int ADDR_WIDTH   = 10,
   parameter int STROBE_HIGH  = 4,
   parameter int STROBE_LOW   = 4,
   parameter int ACK_TIMEOUT  = 1024
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  start_i,
   sobel_window_feeder_if.master bus,
   output logic                  busy_o,
   output logic                  frame_done_o,
   output logic [15:0]           window_count_o,
   output logic                  error_o
);
   localparam int STB_MAX = (STROBE_HIGH > STROBE_LOW) ? STROBE_HIGH : STROBE_LOW;
   localparam int STB_W   = $clog2(STB_MAX);
   localparam logic [STB_W-1:0] HI_LAST = STB_W'(STROBE_HIGH - 1);
   localparam logic [STB_W-1:0] LO_LAST = STB_W'(STROBE_LOW - 1);

   feeder_state_e         state_r;
   feeder_state_e         state_next_s;
   logic [STB_W-1:0]      phase_cnt_r;
   logic                  comp_q_r;
   logic                  low_seen_r;
   logic                  ack_s;
   logic                  wait_expired_s;
   logic                  frame_clr_s;
   logic                  pix_step_s;
   logic                  win_step_s;
   logic                  last_pix_s;
   logic                  last_win_s;
   logic [ADDR_WIDTH-1:0] addr_s;

   sobel_window_addr_gen #(
      .IMAGE_WIDTH (IMAGE_WIDTH),
      .IMAGE_HEIGHT(IMAGE_HEIGHT),
      .ADDR_WIDTH  (ADDR_WIDTH)
   ) u_addr_gen (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .frame_clr_i(frame_clr_s),
      .pix_step_i (pix_step_s),
      .win_step_i (win_step_s),
      .addr_o     (addr_s),
      .last_pix_o (last_pix_s),
      .last_win_o (last_win_s)
   );

   assign bus.mem_addr_o = addr_s;

   // An acknowledge needs the registered completion level to have been seen
   // low during this wait, so a level still high from the last window is ignored.
   assign ack_s = comp_q_r & low_seen_r;

   // State register.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state decode and counter step enables.
   always_comb begin
      state_next_s = state_r;
      frame_clr_s  = 1'b0;
      pix_step_s   = 1'b0;
      win_step_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start_i) begin
               state_next_s = ST_FETCH;
               frame_clr_s  = 1'b1;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_FETCH:     state_next_s = ST_LATCH;
         ST_LATCH:     state_next_s = ST_STROBE_HI;
         ST_STROBE_HI: begin
            if (phase_cnt_r == HI_LAST) begin
               state_next_s = ST_STROBE_LO;
            end else begin
               state_next_s = ST_STROBE_HI;
            end
         end
         ST_STROBE_LO: begin
            if (phase_cnt_r != LO_LAST) begin
               state_next_s = ST_STROBE_LO;
            end else if (last_pix_s) begin
               state_next_s = ST_WAIT_ACK;
            end else begin
               state_next_s = ST_FETCH;
               pix_step_s   = 1'b1;
            end
         end
         ST_WAIT_ACK: begin
            if (ack_s) begin
               state_next_s = ST_NEXT_WIN;
            end else if (wait_expired_s) begin
               state_next_s = ST_DONE;
            end else begin
               state_next_s = ST_WAIT_ACK;
            end
         end
         ST_NEXT_WIN: begin
            win_step_s = 1'b1;
            if (last_win_s) begin
               state_next_s = ST_DONE;
            end else begin
               state_next_s = ST_FETCH;
            end
         end
         ST_DONE:      state_next_s = ST_IDLE;
         default:      state_next_s = ST_IDLE;
      endcase
   end

   // Cycles spent in the current state; restarts on every state change.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         phase_cnt_r <= '0;
      end else if (state_next_s != state_r) begin
         phase_cnt_r <= '0;
      end else begin
         phase_cnt_r <= phase_cnt_r + STB_W'(1);
      end
   end

   // Register the controller's completion level and arm on a low sample.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         comp_q_r   <= 1'b0;
         low_seen_r <= 1'b0;
      end else begin
         comp_q_r   <= bus.px_completed_i;
         low_seen_r <= (state_r == ST_WAIT_ACK) && (low_seen_r || !comp_q_r);
      end
   end

   // Registered outputs, decoded from the state being entered.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         bus.mem_rd_o    <= 1'b0;
         bus.px_enable_o <= 1'b0;
         bus.px_gray_o   <= '0;
         busy_o          <= 1'b0;
         frame_done_o    <= 1'b0;
         window_count_o  <= 16'd0;
      end else begin
         bus.mem_rd_o    <= (state_next_s == ST_FETCH);
         bus.px_enable_o <= (state_next_s == ST_STROBE_HI);
         busy_o          <= (state_next_s != ST_IDLE);
         frame_done_o    <= (state_next_s == ST_DONE);
         if (state_r == ST_LATCH) begin
            bus.px_gray_o <= PIXEL_WIDTH'(bus.mem_data_i);
         end
         if (frame_clr_s) begin
            window_count_o <= 16'd0;
         end else if (win_step_s) begin
            window_count_o <= window_count_o + 16'd1;
         end
      end
   end

`ifdef SOBEL_FEEDER_TIMEOUT_EN
   localparam int WAIT_W = $clog2(ACK_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);

   logic [WAIT_W-1:0] wait_cnt_r;

   assign wait_expired_s = (wait_cnt_r == WAIT_LAST);

   // Watchdog: cycles spent waiting for the current acknowledge.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         wait_cnt_r <= '0;
      end else if (state_r == ST_WAIT_ACK) begin
         wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
      end else begin
         wait_cnt_r <= '0;
      end
   end

   // Sticky error, cleared only by reset or a new frame.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         error_o <= 1'b0;
      end else if (frame_clr_s) begin
         error_o <= 1'b0;
      end else if ((state_r == ST_WAIT_ACK) && !ack_s && wait_expired_s) begin
         error_o <= 1'b1;
      end
   end
`else
   assign wait_expired_s = 1'b0;
   assign error_o        = 1'b0;
`endif

endmodule

// File: tb/tb_sobel_window_feeder.sv
// Directed bench for sobel_window_feeder on a 5x4 frame (6 windows).
// Memory returns address+0x40; a negedge monitor logs reads and strobes.
module tb_sobel_window_feeder;

   localparam int W  = 5;
   localparam int H  = 4;
   localparam int AW = 10;
   localparam int PW = 8;
   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        busy;
   logic        frame_done;
   logic        error;
   logic [15:0] win_cnt;

   sobel_window_feeder_if #(.PIXEL_WIDTH(PW), .ADDR_WIDTH(AW)) bus_if ();

   sobel_window_feeder #(
      .PIXEL_WIDTH (PW),
      .IMAGE_WIDTH (W),
      .IMAGE_HEIGHT(H),
      .ADDR_WIDTH  (AW),
      .STROBE_HIGH (4),
      .STROBE_LOW  (4),
      .ACK_TIMEOUT (TO)
   ) dut (
      .clk_i         (clk),
      .reset_i       (reset),
      .start_i       (start),
      .bus           (bus_if),
      .busy_o        (busy),
      .frame_done_o  (frame_done),
      .window_count_o(win_cnt),
      .error_o       (error)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // synchronous frame buffer, one-cycle read latency
   always @(posedge clk) begin
      if (bus_if.mem_rd_o) bus_if.mem_data_i <= bus_if.mem_addr_o[7:0] + 8'h40;
   end

   int         rd_q[$];
   int         gray_q[$];
   int         rise_q[$];
   int         rise_cnt = 0;
   int         done_cnt = 0;
   int         unstable_cnt = 0;
   logic       prev_en = 1'b0;
   logic       have_gray = 1'b0;
   logic [7:0] last_gray = 8'h00;

   always @(negedge clk) begin
      prev_en <= bus_if.px_enable_o;
      if (bus_if.mem_rd_o) rd_q.push_back(int'(bus_if.mem_addr_o));
      if (frame_done) done_cnt <= done_cnt + 1;
      if (reset) begin
         have_gray <= 1'b0;
      end else if (bus_if.px_enable_o && !prev_en) begin
         rise_cnt  <= rise_cnt + 1;
         rise_q.push_back(cyc);
         gray_q.push_back(int'(bus_if.px_gray_o));
         last_gray <= bus_if.px_gray_o;
         have_gray <= 1'b1;
      end else if (have_gray && (bus_if.px_gray_o != last_gray)) begin
         unstable_cnt <= unstable_cnt + 1;
      end
   end

   int errors = 0;
   int checks = 0;

   task automatic check_eq(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_cyc(input int target);
      while (cyc < target) tick();
   endtask

   task automatic wait_rises(input int target);
      int budget;
      budget = 3000;
      while (rise_cnt < target && budget > 0) begin
         tick();
         budget--;
      end
      check_eq("rise_wait", int'(rise_cnt >= target), 1);
   endtask

   task automatic do_start(output int s);
      start = 1'b1;
      s     = cyc;
      tick();
      start = 1'b0;
   endtask

   // Raise completion now; three cycles later the next FETCH (or DONE) is due.
   task automatic raise_ack(input int exp_count, input bit last);
      bus_if.px_completed_i = 1'b1;
      tick();
      tick();
      tick();
      check_eq("win_count_after_ack", int'(win_cnt), exp_count);
      if (last) check_eq("done_after_ack", int'(frame_done), 1);
      else      check_eq("fetch_after_ack", int'(bus_if.mem_rd_o), 1);
      bus_if.px_completed_i = 1'b0;
   endtask

   // Acknowledge 5 cycles after WAIT_ACK entry (8 cycles after the 9th rise).
   task automatic ack_window(input int exp_count, input bit last);
      int ent;
      ent = rise_q[rise_q.size()-1] + 8;
      wait_cyc(ent + 5);
      raise_ack(exp_count, last);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int s, rb, db, rd0, g0, r0, idx, a, ent;
      reset = 1'b1;
      start = 1'b0;
      bus_if.px_completed_i = 1'b0;
      repeat (3) tick();
      check_eq("rst_mem_rd", int'(bus_if.mem_rd_o), 0);
      check_eq("rst_enable", int'(bus_if.px_enable_o), 0);
      check_eq("rst_gray", int'(bus_if.px_gray_o), 0);
      check_eq("rst_addr", int'(bus_if.mem_addr_o), 0);
      check_eq("rst_busy", int'(busy), 0);
      check_eq("rst_done", int'(frame_done), 0);
      check_eq("rst_count", int'(win_cnt), 0);
      check_eq("rst_error", int'(error), 0);
      reset = 1'b0;
      tick();

      // ---------------- frame A: complete frame ----------------
      rd0 = rd_q.size(); g0 = gray_q.size(); r0 = rise_q.size();
      rb = rise_cnt; db = done_cnt;
      do_start(s);
      check_eq("fetch_busy", int'(busy), 1);
      check_eq("fetch_rd", int'(bus_if.mem_rd_o), 1);
      check_eq("fetch_addr0", int'(bus_if.mem_addr_o), 0);
      for (int w = 0; w < 6; w++) begin
         wait_rises(rb + 9 * (w + 1));
         ack_window(w + 1, w == 5);
      end
      tick();
      check_eq("idle_busy", int'(busy), 0);
      check_eq("done_width", int'(frame_done), 0);
      check_eq("done_pulses", done_cnt - db, 1);
      check_eq("final_count", int'(win_cnt), 6);
      check_eq("error_clear", int'(error), 0);
      check_eq("start_latency", rise_q[r0] - s, 3);
      check_eq("read_count", rd_q.size() - rd0, 54);
      check_eq("rise_count", gray_q.size() - g0, 54);
      if (rd_q.size() - rd0 == 54 && gray_q.size() - g0 == 54) begin
         idx = 0;
         for (int r = 0; r < H - 2; r++) begin
            for (int c = 0; c < W - 2; c++) begin
               for (int k = 0; k < 9; k++) begin
                  a = (r + k / 3) * W + c + k % 3;
                  check_eq("rd_addr", rd_q[rd0 + idx], a);
                  check_eq("px_gray", gray_q[g0 + idx], (a + 64) & 255);
                  idx++;
               end
            end
         end
         for (int w = 0; w < 6; w++) begin
            for (int p = 1; p < 9; p++) begin
               check_eq("rise_gap", rise_q[r0 + w * 9 + p] - rise_q[r0 + w * 9 + p - 1], 10);
            end
         end
      end

      // ---------------- frame B: stale-high ack, then reset ----------------
      rb = rise_cnt;
      do_start(s);
      wait_rises(rb + 9);
      ent = rise_q[rise_q.size()-1] + 8;
      bus_if.px_completed_i = 1'b1;   // already high when WAIT_ACK is entered
      wait_cyc(ent + 6);
      check_eq("held_no_advance", int'(win_cnt), 0);
      check_eq("held_busy", int'(busy), 1);
      check_eq("held_no_fetch", int'(bus_if.mem_rd_o), 0);
      bus_if.px_completed_i = 1'b0;
      tick();
      tick();
      raise_ack(1, 1'b0);
      wait_rises(rb + 18);
      ack_window(2, 1'b0);
      wait_rises(rb + 19);
      check_eq("win2_strobe_hi", int'(bus_if.px_enable_o), 1);
      reset = 1'b1;
      #1;
      check_eq("mid_rst_enable", int'(bus_if.px_enable_o), 0);
      check_eq("mid_rst_rd", int'(bus_if.mem_rd_o), 0);
      check_eq("mid_rst_busy", int'(busy), 0);
      check_eq("mid_rst_count", int'(win_cnt), 0);
      check_eq("mid_rst_gray", int'(bus_if.px_gray_o), 0);
      check_eq("mid_rst_addr", int'(bus_if.mem_addr_o), 0);
      tick();
      reset = 1'b0;
      tick();

      // ---------------- frame C: restart after reset ----------------
      rd0 = rd_q.size(); g0 = gray_q.size(); r0 = rise_q.size();
      rb = rise_cnt; db = done_cnt;
      do_start(s);
      wait_rises(rb + 1);
      check_eq("restart_addr", rd_q[rd0], 0);
      check_eq("restart_gray", gray_q[g0], 8'h40);
      check_eq("restart_latency", rise_q[r0] - s, 3);
      wait_rises(rb + 9);
      ent = rise_q[rise_q.size()-1] + 8;
`ifdef SOBEL_FEEDER_TIMEOUT_EN
      wait_cyc(ent + 15);
      check_eq("to_not_yet_err", int'(error), 0);
      check_eq("to_not_yet_done", int'(frame_done), 0);
      tick();
      check_eq("to_error", int'(error), 1);
      check_eq("to_done", int'(frame_done), 1);
      tick();
      check_eq("to_idle", int'(busy), 0);
      check_eq("to_error_sticky", int'(error), 1);
      check_eq("to_done_pulses", done_cnt - db, 1);
`else
      wait_cyc(ent + 40);
      check_eq("wait_forever_busy", int'(busy), 1);
      check_eq("wait_forever_err", int'(error), 0);
      check_eq("wait_forever_done", done_cnt - db, 0);
`endif
      check_eq("gray_stable", unstable_cnt, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sobel_window_feeder.md
# sobel_window_feeder

Transmit side of the Sobel pixel-strobe interface. Reads the grayscale frame from a synchronous frame buffer and presents it one pixel at a time as 3x3 windows on `px_gray_o`/`px_enable_o`, the input port pair of the Sobel kernel controller. It waits for the controller's per-window completion pulse before sending the next window, and signals end of frame.

## Interface
- `PIXEL_WIDTH`, 8: gray pixel width.
- `IMAGE_WIDTH`, 32: frame columns (≥3).
- `IMAGE_HEIGHT`, 32: frame rows (≥3).
- `ADDR_WIDTH`, 10: frame-buffer address width; must satisfy 2^ADDR_WIDTH ≥ IMAGE_WIDTH*IMAGE_HEIGHT.
- `STROBE_HIGH`, 4: cycles `px_enable_o` is held high per pixel (≥4).
- `STROBE_LOW`, 4: cycles `px_enable_o` is held low after each high phase (≥4).
- `ACK_TIMEOUT`, 1024: watchdog limit in cycles; used only with the macro.
- `clk_i` in 1: single clock.
- `reset_i` in 1: asynchronous, active-high reset.
- `start_i` in 1: one-cycle frame start request.
- `mem_rd_o` out 1: frame-buffer read strobe.
- `mem_addr_o` out ADDR_WIDTH: read address, equal to row*IMAGE_WIDTH+col.
- `mem_data_i` in PIXEL_WIDTH: read data, valid the cycle after `mem_rd_o`.
- `px_gray_o` out PIXEL_WIDTH: pixel to controller.
- `px_enable_o` out 1: pixel strobe; the controller counts its rising edges.
- `px_completed_i` in 1: window-done level from the controller.
- `busy_o` out 1: frame in progress.
- `frame_done_o` out 1: one-cycle pulse after the last window is acknowledged.
- `window_count_o` out 16: windows acknowledged in the current frame.
- `error_o` out 1: sticky watchdog error flag.

## Operation
- States: IDLE, FETCH, LATCH, STROBE_HI, STROBE_LO, WAIT_ACK, NEXT_WIN, DONE.
- IDLE→FETCH on `start_i`. This clears row r, column c, pixel index k, `window_count_o` and `error_o`. `start_i` is ignored outside IDLE.
- Pixel k (0..8) comes from row r+k/3, column c+k%3. Order is row-major within the window.
- FETCH: `mem_rd_o`=1, `mem_addr_o`=(r+k/3)*IMAGE_WIDTH+(c+k%3).
- LATCH: `px_gray_o`<=`mem_data_i`.
- STROBE_HI: `px_enable_o`=1 for STROBE_HIGH cycles.
- STROBE_LO: `px_enable_o`=0 for STROBE_LOW cycles. Then go to FETCH with k+1, or to WAIT_ACK if k==8.
- `px_gray_o` changes only in LATCH. It is stable from before each rising edge of `px_enable_o` until the next LATCH, which covers the controller's 2-flop synchronizer delay.
- WAIT_ACK: `px_completed_i` is registered. A detected 0→1 edge moves to NEXT_WIN. A level already high on entry does not count.
- NEXT_WIN: `window_count_o`+1, k=0. If c<IMAGE_WIDTH-3 then c+1. Else c=0 and r+1. If the window just acknowledged was r=IMAGE_HEIGHT-3, c=IMAGE_WIDTH-3, go to DONE; otherwise go to FETCH.
- DONE: `frame_done_o`=1 for one cycle, then IDLE.
- `busy_o`=1 in every state except IDLE.
- Total windows per frame: (IMAGE_WIDTH-2)*(IMAGE_HEIGHT-2).

## Timing
- Reset values: all outputs 0, state IDLE. Reset mid-frame drops `px_enable_o` and `mem_rd_o` in the same cycle and abandons the frame.
- Per pixel: 2+STROBE_HIGH+STROBE_LOW cycles (10 with defaults).
- Latency from `start_i` to the first `px_enable_o` rise: 3 cycles (IDLE→FETCH→LATCH→STROBE_HI).
- Latency from the acknowledge edge detected to the next FETCH: 1 cycle (NEXT_WIN).
- If `reset_i` and `start_i` are high together, reset wins.

## Configuration
- `SOBEL_FEEDER_TIMEOUT_EN` defined: a WAIT_ACK cycle counter runs. Reaching ACK_TIMEOUT sets `error_o`, pulses `frame_done_o` and returns to IDLE.
- Not defined: WAIT_ACK waits indefinitely, no counter is synthesized, and `error_o` is tied to 0.

## Structure
- Shared package `sobel_pkg`: the PIXEL_WIDTH, IMAGE_WIDTH and IMAGE_HEIGHT defaults and the feeder state enum. The Sobel controller uses the same package constants.
- Sub-module `sobel_window_addr_gen`: r/c/k counters, address arithmetic and the last-window flag, stepped by FSM enables.

## Test plan
- IMAGE_WIDTH=5, IMAGE_HEIGHT=4, `start_i` pulse -> window 0 reads addresses 0,1,2,5,6,7,10,11,12 in order. 9 rising edges on `px_enable_o`, each 10 cycles apart.
- Same frame, acknowledge each window 5 cycles after WAIT_ACK entry -> window 1 addresses start at 1; window 3 starts at 5; window 5 reads 7,8,9,12,13,14,17,18,19. `window_count_o`=6 with `frame_done_o` pulsing once.
- Memory returns data = address+0x40 -> `px_gray_o` = 0x40,0x41,0x42,0x45… and is stable across each high phase plus the following low phase.
- `px_completed_i` held high when WAIT_ACK is entered -> no advance until it falls and rises again.
- `reset_i` asserted in STROBE_HI of window 2 -> `px_enable_o`=0 immediately and all outputs 0. A new `start_i` then restarts at address 0.
- With `SOBEL_FEEDER_TIMEOUT_EN` and ACK_TIMEOUT=16, no acknowledge -> `error_o`=1 and `frame_done_o` pulse 16 cycles after WAIT_ACK entry, then `busy_o`=0.
